// File: rtl/alarm_pkg.sv
// Shared constants and repeat-engine state encoding for the alarm-time entry stage.
package alarm_pkg;

    localparam int TW = 6;
    localparam logic [TW-1:0] HR_MAX  = 6'd23;
    localparam logic [TW-1:0] MIN_MAX = 6'd59;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/btn_repeat.sv
// Press-and-hold repeat engine: one step on the rising edge, then after
// REPEAT_DELAY cycles a step every REPEAT_RATE cycles while held.
module btn_repeat
    import alarm_pkg::*;
#(
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic force_idle,
    output logic step
);

    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DLY_END = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RPT_END = CW'(REPEAT_RATE - 1);

    rpt_state_e     r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_prev;
    logic           r_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RPT_IDLE;
            r_cnt   <= '0;
            r_prev  <= 1'b0;
            r_step  <= 1'b0;
        end else begin
            // Previous sample tracks even while forced idle, so a held button needs a re-press.
            r_prev <= btn;
            r_step <= 1'b0;
            if (force_idle || !btn) begin
                r_state <= RPT_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    RPT_IDLE: begin
                        if (!r_prev) begin
                            r_step  <= 1'b1;
                            r_state <= RPT_DELAY;
                            r_cnt   <= '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (r_cnt == DLY_END) begin
                            r_step  <= 1'b1;
                            r_state <= RPT_REPEAT;
                            r_cnt   <= '0;
                        end else if (r_cnt < DLY_END) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (r_cnt == RPT_END) begin
                            r_step <= 1'b1;
                            r_cnt  <= '0;
                        end else if (r_cnt < RPT_END) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= RPT_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign step = r_step;

endmodule

// File: rtl/alarm_set.sv
// Alarm-time entry: holds alarm hour/minute, applies wrapped steps from two
// repeat engines, clear-to-default, edit lock and a change pulse.
module alarm_set
    import alarm_pkg::*;
#(
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000,
    parameter int DEFAULT_HR   = 6,
    parameter int DEFAULT_MIN  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    btn,
    input  logic          set_lock,
    output logic [TW-1:0] a_hr,
    output logic [TW-1:0] a_min,
    output logic          changed
);

    localparam logic [TW-1:0] DEF_HR  = TW'(DEFAULT_HR);
    localparam logic [TW-1:0] DEF_MIN = TW'(DEFAULT_MIN);

    logic [TW-1:0] r_hr, r_min;
    logic          r_changed;
    logic          r_clr_prev, r_clr;
    logic          w_clr_edge, w_force_idle;
    logic          w_hr_step, w_min_step;
    logic [TW-1:0] w_hr_nxt, w_min_nxt;
    logic          w_unused_btn;

    assign w_unused_btn = btn[1];

    // A clear press also parks both engines so a simultaneous step press is dropped.
    assign w_clr_edge   = btn[0] & ~r_clr_prev & ~set_lock;
    assign w_force_idle = set_lock | w_clr_edge;

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_hr_rpt (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn[2]),
        .force_idle (w_force_idle),
        .step       (w_hr_step)
    );

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_min_rpt (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn[3]),
        .force_idle (w_force_idle),
        .step       (w_min_step)
    );

    always_comb begin
        w_hr_nxt  = r_hr;
        w_min_nxt = r_min;
        if (r_clr) begin
            w_hr_nxt  = DEF_HR;
            w_min_nxt = DEF_MIN;
        end else begin
            if (w_hr_step)
                w_hr_nxt = (r_hr == HR_MAX) ? '0 : r_hr + 1'b1;
            if (w_min_step)
                w_min_nxt = (r_min == MIN_MAX) ? '0 : r_min + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hr       <= DEF_HR;
            r_min      <= DEF_MIN;
            r_changed  <= 1'b0;
            r_clr_prev <= 1'b0;
            r_clr      <= 1'b0;
        end else begin
            r_clr_prev <= btn[0];
            r_clr      <= w_clr_edge;
            r_hr       <= w_hr_nxt;
            r_min      <= w_min_nxt;
            r_changed  <= (w_hr_nxt != r_hr) || (w_min_nxt != r_min);
        end
    end

    assign a_hr    = r_hr;
    assign a_min   = r_min;
    assign changed = r_changed;

endmodule

// File: doc/alarm_set.md
# alarm_set

Alarm-time entry stage feeding the alarm/display block. Converts button presses into a stored alarm time (`a_hr`, `a_min`, binary) with single-step and hold-to-repeat auto-increment, wrap-around and clear-to-default. Outputs drive the alarm block's alarm-hour/alarm-minute inputs directly. The block also flags every change so the display can show the alarm time.

## Interface
- `REPEAT_DELAY`, default 500000: cycles a button is held before auto-repeat starts (≥1).
- `REPEAT_RATE`, default 100000: cycles between auto-repeat steps (≥1).
- `DEFAULT_HR`, default 6: hour loaded at reset and on clear (0..23).
- `DEFAULT_MIN`, default 0: minute loaded at reset and on clear (0..59).

Ports:
- `clk` in 1: system clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `btn` in 4: debounced, clk-synchronous button levels. [0] clear, [2] hour step, [3] minute step, [1] unused.
- `set_lock` in 1: high blocks all edits.
- `a_hr` out 6: alarm hour, 0..23.
- `a_min` out 6: alarm minute, 0..59.
- `changed` out 1: one-cycle pulse when `a_hr` or `a_min` takes a new value.

## Operation
- Reset: `a_hr`=DEFAULT_HR, `a_min`=DEFAULT_MIN, `changed`=0, both repeat engines IDLE, counters 0.
- One repeat engine per step button (hour, minute), independent.
- Engine states:
  - IDLE: on btn rising (btn=1, previous sample 0), emit step and go to DELAY, count=0.
  - DELAY: count up. At count=REPEAT_DELAY-1, emit step, go to REPEAT, count=0.
  - REPEAT: at count=REPEAT_RATE-1, emit step, count=0.
  - Any state: btn=0 returns the engine to IDLE and clears count in the same cycle.
- Hour step: `a_hr` = (a_hr==23) ? 0 : a_hr+1.
- Minute step: `a_min` = (a_min==59) ? 0 : a_min+1. No carry into hour.
- Clear: rising edge of btn[0] loads both defaults. Clear has priority over any step in the same cycle, and both engines return to IDLE.
- Hour and minute steps in the same cycle are both applied.
- `set_lock`=1: steps and clear are ignored and both engines are forced to IDLE. Outputs hold. A button already held when the lock releases does not step until it is released and pressed again, because the previous-sample register keeps tracking during lock.
- `changed`=1 only when the stored value actually differs. Clear while already at the defaults gives `changed`=0.
- Counter width: $clog2 of the larger of REPEAT_DELAY and REPEAT_RATE. Counters saturate-safe, never wrap past their terminal value.

## Timing
- Button first sampled high at edge k: step decoded and registered at k, so `a_hr`/`a_min` show the new value after edge k+1. `changed` is high for exactly the cycle after edge k+1.
- First repeat step lands REPEAT_DELAY cycles after the initial step. Later steps land every REPEAT_RATE cycles.
- Asynchronous reset mid-hold: outputs return to defaults immediately. After `rst_n` deasserts, a still-held button counts as previous=0, so it steps once on the first edge, then follows the normal delay.
- All outputs are registered. No combinational path from `btn` to any output.

## Structure
- Shared package `alarm_pkg`:
  - HR_MAX=23, MIN_MAX=59, time field width 6.
  - Repeat-engine state encoding IDLE/DELAY/REPEAT.
- Sub-module `btn_repeat`, instantiated twice (hour, minute):
  - Inputs: `clk`, `rst_n`, `btn`, `force_idle`.
  - Output: `step` pulse.
  - Parameters: REPEAT_DELAY, REPEAT_RATE.
- The top level holds the time registers, wrap logic, clear edge detection, lock and `changed`.

## Test plan
- Reset, then a 1-cycle btn[3] pulse: `a_min` 0→1 two edges after the pulse is sampled, `changed` high for one cycle, `a_hr`=6 unchanged.
- REPEAT_DELAY=10, REPEAT_RATE=4, hold btn[2] for 30 cycles from hour 22:
  - Steps after 1, 11, 15, 19, 23 and 27 cycles.
  - Hour sequence 23, 0, 1, 2, 3, 4. No carry into minutes.
- Minute at 59, press btn[3]: `a_min`=0 and `a_hr` unchanged.
- btn[0], btn[2] and btn[3] rise in the same cycle with time at 10:20: result 06:00, `changed` pulses. Clearing again from 06:00: `changed` stays 0.
- Hold btn[3] with `set_lock`=1 for 20 cycles, then release the lock while still holding: no change. After release and a fresh press, exactly one step.
- Assert `rst_n` low mid-repeat while btn[2] is held: immediate 06:00. After release of reset, a single step to 07:00, then the next step REPEAT_DELAY cycles later.
